// File: rtl/sdpb_pingpong_buffer.sv
// Ping-pong frame buffer on two simple-dual-port RAM banks with write-to-read width
// conversion, handshaked write pointer, automatic bank swapping and a 2-cycle read path.
module sdpb_pingpong_buffer #(
    parameter int WR_WIDTH        = 32,
    parameter int RATIO           = 4,
    parameter int DEPTH           = 512,
    parameter int SWAP_ON_RELEASE = 1,
    localparam int RD_WIDTH = WR_WIDTH / RATIO,
    localparam int AW       = $clog2(DEPTH),
    localparam int RAW      = $clog2(DEPTH * RATIO)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [WR_WIDTH-1:0] wr_data,
    input  logic                wr_last,
    input  logic                rd_en,
    input  logic [RAW-1:0]      rd_addr,
    output logic [RD_WIDTH-1:0] rd_data,
    output logic                rd_valid,
    input  logic                rd_release,
    output logic                rd_bank_valid,
    output logic [AW:0]         rd_len,
    output logic [15:0]         swap_count
);

    localparam int KW = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [0:0] {FILL = 1'b0, COMPLETE = 1'b1} state_t;

    state_t              state_r, state_s;
    logic                wr_bank_r, wr_bank_s;
    logic                rd_bank_r, rd_bank_s;
    logic [AW-1:0]       wr_ptr_r, wr_ptr_s;
    logic [AW:0]         fill_len_r, fill_len_s;
    logic                release_pending_r, release_pending_s;
    logic                rd_bank_valid_r, rd_bank_valid_s;
    logic [AW:0]         rd_len_r, rd_len_s;
    logic [15:0]         swap_count_r, swap_count_s;
    logic                wr_ready_r, wr_ready_s;
    logic                wr_fire_s;

    logic [WR_WIDTH-1:0] mem_r [0:2*DEPTH-1];
    logic [WR_WIDTH-1:0] ram_q_r;
    logic [AW-1:0]       word_s;
    logic [KW-1:0]       k_s;
    logic [RAW:0]        lim_s;
    logic                zero_s;
    logic                s1_valid_r, s1_zero_r;
    logic [KW-1:0]       s1_k_r;
    logic [RD_WIDTH-1:0] sub_s;
    logic [RD_WIDTH-1:0] rd_data_r;
    logic                rd_valid_r;

    assign wr_fire_s = wr_valid & wr_ready_r;

    // Write FSM next-state, bank swap and release bookkeeping
    always_comb begin
        state_s           = state_r;
        wr_bank_s         = wr_bank_r;
        rd_bank_s         = rd_bank_r;
        wr_ptr_s          = wr_ptr_r;
        fill_len_s        = fill_len_r;
        release_pending_s = release_pending_r;
        rd_bank_valid_s   = rd_bank_valid_r;
        rd_len_s          = rd_len_r;
        swap_count_s      = swap_count_r;
        case (state_r)
            FILL: begin
                if (rd_release && rd_bank_valid_r) begin
                    release_pending_s = 1'b1;
                end else begin
                    release_pending_s = release_pending_r;
                end
                if (wr_fire_s) begin
                    wr_ptr_s = wr_ptr_r + AW'(1);
                    if (wr_last || (wr_ptr_r == AW'(DEPTH - 1))) begin
                        fill_len_s = (AW+1)'(wr_ptr_r) + (AW+1)'(1);
                        state_s    = COMPLETE;
                    end else begin
                        state_s    = FILL;
                    end
                end else begin
                    wr_ptr_s = wr_ptr_r;
                end
            end
            COMPLETE: begin
                // An empty read side always accepts a frame; otherwise the mode decides
                if (!rd_bank_valid_r || (SWAP_ON_RELEASE == 0) || rd_release || release_pending_r) begin
                    wr_bank_s         = rd_bank_r;
                    rd_bank_s         = wr_bank_r;
                    rd_bank_valid_s   = 1'b1;
                    rd_len_s          = fill_len_r;
                    swap_count_s      = swap_count_r + 16'd1;
                    release_pending_s = 1'b0;
                    wr_ptr_s          = '0;
                    state_s           = FILL;
                end else begin
                    state_s           = COMPLETE;
                end
            end
            default: begin
                state_s = FILL;
            end
        endcase
        wr_ready_s = (state_s == FILL);
    end

    // Write-side state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= FILL;
            wr_bank_r         <= 1'b0;
            rd_bank_r         <= 1'b1;
            wr_ptr_r          <= '0;
            fill_len_r        <= '0;
            release_pending_r <= 1'b0;
            rd_bank_valid_r   <= 1'b0;
            rd_len_r          <= '0;
            swap_count_r      <= 16'd0;
            wr_ready_r        <= 1'b0;
        end else begin
            state_r           <= state_s;
            wr_bank_r         <= wr_bank_s;
            rd_bank_r         <= rd_bank_s;
            wr_ptr_r          <= wr_ptr_s;
            fill_len_r        <= fill_len_s;
            release_pending_r <= release_pending_s;
            rd_bank_valid_r   <= rd_bank_valid_s;
            rd_len_r          <= rd_len_s;
            swap_count_r      <= swap_count_s;
            wr_ready_r        <= wr_ready_s;
        end
    end

    // Read address decode: word index, sub-word lane and out-of-frame detection at issue
    assign word_s = AW'(rd_addr / RATIO);
    assign k_s    = KW'(rd_addr % RATIO);
    assign lim_s  = (RAW+1)'(rd_len_r) * (RAW+1)'(RATIO);
    assign zero_s = ({1'b0, rd_addr} >= lim_s) || !rd_bank_valid_r;

    // RAM banks: capture-side write port, registered read port on the bank latched at issue
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[{wr_bank_r, wr_ptr_r}] <= wr_data;
        end
        if (rd_en) begin
            ram_q_r <= mem_r[{rd_bank_r, word_s}];
        end
    end

    assign sub_s = RD_WIDTH'(ram_q_r >> (RD_WIDTH * int'(s1_k_r)));

    // Read pipeline control and output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_zero_r  <= 1'b0;
            s1_k_r     <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            s1_valid_r <= rd_en;
            s1_zero_r  <= zero_s;
            s1_k_r     <= k_s;
            rd_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                rd_data_r <= s1_zero_r ? '0 : sub_s;
            end
        end
    end

    assign wr_ready      = wr_ready_r;
    assign rd_data       = rd_data_r;
    assign rd_valid      = rd_valid_r;
    assign rd_bank_valid = rd_bank_valid_r;
    assign rd_len        = rd_len_r;
    assign swap_count    = swap_count_r;

endmodule
